if_stage: RTL
=============

// Module: if_stage
// PURPOSE
//  Fetch stage of the 5-stage RV32I pipeline; producer side of if_to_id_bus and if_to_id_valid, consumed by id_stage.
//  Holds the fetch PC and drives the synchronous IROM address so irom_inst is valid in the cycle ID holds that PC.
//  Redirects on trap (mtvec/mepc) and taken branch/jump. Honours the ID allow-in handshake.
// PARAMETERS
//  RESET_PC  32'h0000_0000  first PC fetched after reset
// PORTS
//  clk              in   1   clock
//  rst_n            in   1   reset, synchronous, active-low
//  id_allow_in      in   1   ID accepts a new instruction this cycle
//  br_taken         in   1   EX taken branch/jump; ID is cancelled by controller the same cycle
//  br_target        in   32  branch/jump target
//  trap_taken       in   1   exception/interrupt/mret redirect
//  trap_target      in   32  mtvec or mepc
//  if_to_id_bus     out  64  {pc4, pc} (`IF_TO_ID_BUS_WIDTH)
//  if_to_id_valid   out  1   bus holds a valid instruction PC
//  irom_addr        out  32  byte address to synchronous IROM (data returns next cycle)
//  fetch_misalign   out  1   only with IF_MISALIGN_CHECK_EN; else tied 0
// BEHAVIOUR
//  State: if_pc, if_valid, id_pc (copy of PC handed to ID), fsm {S_BOOT, S_RUN, S_FAULT}.
//  Reset (rst_n=0 at clk edge): fsm=S_BOOT, if_valid=0, if_pc=RESET_PC, id_pc=RESET_PC;
//   outputs: if_to_id_valid=0, irom_addr=RESET_PC, fetch_misalign=0.
//  S_BOOT -> S_RUN after one cycle; if_valid<=1 (first PC RESET_PC presented next cycle).
//  Handshake: transfer when if_to_id_valid && id_allow_in; IF ready_go=1 always.
//   On transfer: id_pc<=if_pc, if_pc<=if_pc+4. Without transfer: if_pc, id_pc hold.
//  irom_addr = transfer ? if_pc : id_pc  (combinational); on ID stall IROM re-reads id_pc so irom_inst stays stable.
//  if_to_id_bus = {if_pc+32'd4, if_pc}; pc4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0).
//  Redirect priority: trap_taken > br_taken > sequential; independent of id_allow_in.
//   Redirect cycle: if_pc<=target, if_valid<=1, id_pc unchanged; the transfer that cycle is cancelled by ID.
//   Target PC appears on bus next cycle -> 2-bubble penalty. id_pc updated on the target's own transfer.
//  trap_taken and br_taken same cycle: trap_target wins, br_target discarded.
//  Redirect during S_BOOT: target replaces RESET_PC; fsm -> S_RUN.
//  rst_n low mid-operation overrides everything, including pending redirect.
// CONFIGURATION
//  Macro IF_MISALIGN_CHECK_EN:
//   defined: S_RUN with if_pc[1:0]!=0 -> S_FAULT; in S_FAULT if_to_id_valid=0, fetch_misalign=1, if_pc frozen;
//    only trap_taken (to an aligned target) leaves S_FAULT -> S_RUN; br_taken ignored in S_FAULT.
//   undefined: target[1:0] forced to 2'b00 on capture; S_FAULT unreachable; fetch_misalign=0.
// STRUCTURE
//  defines.v: `IF_TO_ID_BUS_WIDTH (64), `RESET_PC default, fsm state encodings (IF_S_BOOT/RUN/FAULT).
//  Sub-module if_npc_mux: combinational next-PC select (trap/branch/seq/hold) with priority above.
//  Top keeps registers, FSM, irom_addr mux.
// TESTING
//  Reset release, id_allow_in=1 -> irom_addr 0,0,4,8...; bus pc 0,4,8 one per cycle from 2nd cycle.
//  Stall: id_allow_in=0 for 3 cycles while ID holds pc=8 -> irom_addr=8 each cycle, bus pc=0xC held, valid=1.
//  br_taken, br_target=0x100 at bus pc=0x10 -> next cycle bus pc=0x100, pc4=0x104; 0x10 not transferred.
//  trap_taken(0x200)+br_taken(0x100) same cycle -> bus pc=0x200.
//  if_pc=0xFFFF_FFFC -> pc4=0x0000_0000; next transfer pc=0.
//  IF_MISALIGN_CHECK_EN: br_target=0x102 -> fetch_misalign=1, valid=0; trap_target=0x80 -> bus pc=0x80, fault cleared.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared types and constants for the IF stage: bus width, reset PC default, fetch FSM states.
package if_stage_pkg;
  localparam int          IF_TO_ID_BUS_WIDTH = 64;
  localparam logic [31:0] IF_RESET_PC        = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_FAULT = 2'd2
  } if_state_e;
endpackage

// File: rtl/if_stage_if.sv
// IF-side bundle: ID handshake, redirect inputs, IF->ID bus and synchronous IROM address.
interface if_stage_if;
  import if_stage_pkg::*;

  logic                          id_allow_in;
  logic                          br_taken;
  logic [31:0]                   br_target;
  logic                          trap_taken;
  logic [31:0]                   trap_target;
  logic [IF_TO_ID_BUS_WIDTH-1:0] if_to_id_bus;
  logic                          if_to_id_valid;
  logic [31:0]                   irom_addr;
  logic                          fetch_misalign;

  modport master (
    input  id_allow_in, br_taken, br_target, trap_taken, trap_target,
    output if_to_id_bus, if_to_id_valid, irom_addr, fetch_misalign
  );

  modport slave (
    output id_allow_in, br_taken, br_target, trap_taken, trap_target,
    input  if_to_id_bus, if_to_id_valid, irom_addr, fetch_misalign
  );
endinterface

// File: rtl/if_stage_npc_mux.sv
// Next-PC select: trap > branch > sequential > hold. Without IF_MISALIGN_CHECK_EN
// redirect targets are word-aligned on capture.
module if_stage_npc_mux
  import if_stage_pkg::*;
(
  input  logic        i_trap_taken,
  input  logic [31:0] i_trap_target,
  input  logic        i_br_taken,
  input  logic [31:0] i_br_target,
  input  logic        i_br_en,
  input  logic        i_seq,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_pc4,
  output logic [31:0] o_npc,
  output logic        o_redirect
);
`ifdef IF_MISALIGN_CHECK_EN
  localparam logic [31:0] TGT_MASK = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] TGT_MASK = 32'hFFFF_FFFC;
`endif

  always_comb begin
    o_redirect = i_trap_taken || (i_br_taken && i_br_en);
    o_npc      = i_pc;
    if (i_trap_taken)                o_npc = i_trap_target & TGT_MASK;
    else if (i_br_taken && i_br_en)  o_npc = i_br_target & TGT_MASK;
    else if (i_seq)                  o_npc = i_pc4;
  end
endmodule

// File: rtl/if_stage.sv
// RV32I fetch stage: PC/FSM registers, IF->ID handshake and IROM address mux.
// Optional IF_MISALIGN_CHECK_EN adds a fault state for misaligned fetch PCs.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IF_RESET_PC
) (
  input  logic       clk,
  input  logic       rst_n,
  if_stage_if.master ifb
);
  if_state_e   r_state, w_state_nxt;
  logic        r_valid, w_valid_nxt;
  logic [31:0] r_pc, r_id_pc;
  logic [31:0] w_npc, w_pc4;
  logic        w_out_valid, w_xfer, w_redirect, w_br_en, w_misalign;

`ifdef IF_MISALIGN_CHECK_EN
  assign w_misalign         = (r_pc[1:0] != 2'b00);
  assign w_br_en            = (r_state != S_FAULT);
  assign ifb.fetch_misalign = (r_state == S_FAULT);
`else
  assign w_misalign         = 1'b0;
  assign w_br_en            = 1'b1;
  assign ifb.fetch_misalign = 1'b0;
`endif

  // A misaligned PC is never offered to ID, even in the cycle before the fault registers.
  assign w_out_valid = r_valid && (r_state == S_RUN) && !w_misalign;
  assign w_xfer      = w_out_valid && ifb.id_allow_in;
  assign w_pc4       = r_pc + 32'd4;

  if_stage_npc_mux u_npc (
    .i_trap_taken  (ifb.trap_taken),
    .i_trap_target (ifb.trap_target),
    .i_br_taken    (ifb.br_taken),
    .i_br_target   (ifb.br_target),
    .i_br_en       (w_br_en),
    .i_seq         (w_xfer),
    .i_pc          (r_pc),
    .i_pc4         (w_pc4),
    .o_npc         (w_npc),
    .o_redirect    (w_redirect)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_valid_nxt = r_valid;
    case (r_state)
      S_BOOT: begin
        w_state_nxt = S_RUN;
        w_valid_nxt = 1'b1;
      end
      S_RUN:   if (!w_redirect && w_misalign) w_state_nxt = S_FAULT;
      S_FAULT: if (ifb.trap_taken) w_state_nxt = S_RUN;
      default: w_state_nxt = S_BOOT;
    endcase
    if (w_redirect) w_valid_nxt = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_BOOT;
      r_valid <= 1'b0;
      r_pc    <= RESET_PC;
      r_id_pc <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      r_valid <= w_valid_nxt;
      r_pc    <= w_npc;
      // ID cancels its slot on a redirect, so the hand-off copy must not advance.
      if (w_xfer && !w_redirect) r_id_pc <= r_pc;
    end
  end

  assign ifb.if_to_id_valid = w_out_valid;
  assign ifb.if_to_id_bus   = {w_pc4, r_pc};
  // On an ID stall IROM re-reads the held PC so the returned instruction stays stable.
  assign ifb.irom_addr      = w_xfer ? r_pc : r_id_pc;
endmodule
